pipeline_run_ctrl: RTL and testbench
====================================

Name: pipeline_run_ctrl

Overview:
Parametrised run/halt controller for the pipelined CPU core. It replaces the fixed "hold run low, then run for a fixed time" sequencing with a reusable block. The block drives the core's run input and supports three modes: free-run with a cycle limit, single-step, and run-to-breakpoint on PC. It sits between the bench or debug host and the core, and reports why and when execution stopped.

Parameters:
PC_WIDTH, 32, width of core PC and breakpoint addresses
CYCLE_WIDTH, 16, width of cycle counter
NUM_BP, 2, number of PC breakpoint comparators (1..8)
MAX_CYCLES, 50, run-cycle limit; 0 = unlimited
START_DELAY, 1, cycles run is held low after start before first run cycle (0 allowed)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  launch pulse; honoured only in IDLE or DONE
mode  in  2  0 free-run, 1 single-step, 2 run-to-breakpoint, 3 reserved (= free-run); sampled on accepted start
step  in  1  single-step request pulse
abort  in  1  force stop
core_halt  in  1  core reports halt instruction retired
pc  in  PC_WIDTH  core current PC
bp_addr  in  NUM_BP*PC_WIDTH  breakpoint i at bits [i*PC_WIDTH +: PC_WIDTH]
bp_en  in  NUM_BP  per-breakpoint enable
run  out  1  registered run enable to core
busy  out  1  high in any state except IDLE and DONE
done  out  1  level; high in DONE
halt_reason  out  3  0 none, 1 core_halt, 2 breakpoint, 3 cycle limit, 4 abort
bp_hit_idx  out  max(1,clog2(NUM_BP))  index of matching breakpoint (valid when halt_reason==2)
cycle_count  out  CYCLE_WIDTH  number of cycles with run==1 since last start

Behaviour:
- Reset (rst high at edge): state IDLE; run=0, busy=0, done=0, halt_reason=0, bp_hit_idx=0, cycle_count=0. Reset mid-run takes effect at that edge; run is low the following cycle.
- States: IDLE, DELAY, RUN, STEP_WAIT, STEP_RUN, DONE. All outputs are registered.
- Start accepted in IDLE/DONE:
  - Clears cycle_count, done, halt_reason and bp_hit_idx.
  - Latches mode.
  - Next state is DELAY with counter=START_DELAY. If START_DELAY=0, go directly to RUN (free/bp) or STEP_WAIT (step).
  - start in any other state is ignored.
- DELAY: run=0; decrement each cycle. At zero, go to RUN or STEP_WAIT.
- RUN: run=1 every cycle. STEP_RUN: run=1 for exactly one cycle, then back to STEP_WAIT. STEP_WAIT: run=0 until step is seen, then STEP_RUN next cycle.
- cycle_count increments on each edge where run==1; saturates at all-ones.
- Stop check happens in every cycle with run==1. Priority, highest first:
  1. abort → reason 4.
  2. core_halt → reason 1.
  3. Breakpoint → reason 2. Applies only when mode==2: some i has bp_en[i] && pc==bp_addr[i]. The lowest i wins and is latched into bp_hit_idx.
  4. Cycle limit → reason 3. Applies when MAX_CYCLES!=0 and cycle_count==MAX_CYCLES-1 (pre-increment).
- On stop: the stopping cycle is counted. Next state is DONE, run=0 on the next cycle, done=1, halt_reason latched.
  - With no other stop, run is therefore high for exactly MAX_CYCLES cycles.
- abort in DELAY or STEP_WAIT → DONE with reason 4. core_halt in STEP_WAIT → DONE with reason 1. abort in IDLE or DONE is ignored.
- step outside STEP_WAIT is ignored. step held high produces one STEP_RUN per STEP_WAIT→STEP_RUN round-trip, i.e. run toggles 1,0,1,0.
- start and abort in the same cycle from DONE: start is accepted and abort is ignored.
- The breakpoint compare is combinational on current pc. There is no resume-past-breakpoint; a restart from DONE re-fires at the same pc if it still matches.

Test Plan:
- Defaults, rst for 2 cycles, start at cycle 3, mode 0, no halt → run low 1 cycle (delay). Then run high exactly 50 cycles, then done=1, halt_reason=3, cycle_count=50.
- mode 2, bp_addr[1]=0x40 enabled, bp_en[0]=0, pc ramps by 4 from 0 each run cycle → stop after the cycle with pc=0x40: cycle_count=17, halt_reason=2, bp_hit_idx=1. Then with bp_en[0]=1 and bp_addr[0]=0x40 as well → bp_hit_idx=0.
- mode 1, three step pulses spaced 5 cycles apart → exactly three single-cycle run pulses, cycle_count=3, done=0, busy=1. Then abort → done, halt_reason=4.
- Free-run, core_halt and abort asserted together at run cycle 10 → halt_reason=4, cycle_count=10. Then core_halt alone at run cycle 7 after restart → halt_reason=1, cycle_count=7.
- rst asserted at run cycle 20 → next cycle run=0, cycle_count=0, done=0, IDLE; a start during rst is ignored.
- MAX_CYCLES=0, CYCLE_WIDTH=4, START_DELAY=0 → run is high on the cycle after start, and cycle_count saturates at 15 with run still high.

Source files
------------

// File: rtl/pipeline_run_ctrl_if.sv
// Host/core-facing signal bundle of the run/halt controller.
interface pipeline_run_ctrl_if #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned CYCLE_WIDTH = 16,
    parameter int unsigned NUM_BP      = 2
) ();
    localparam int unsigned BP_IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

    logic                         start;
    logic [1:0]                   mode;
    logic                         step;
    logic                         abort;
    logic                         core_halt;
    logic [PC_WIDTH-1:0]          pc;
    logic [NUM_BP*PC_WIDTH-1:0]   bp_addr;
    logic [NUM_BP-1:0]            bp_en;
    logic                         run;
    logic                         busy;
    logic                         done;
    logic [2:0]                   halt_reason;
    logic [BP_IDX_W-1:0]          bp_hit_idx;
    logic [CYCLE_WIDTH-1:0]       cycle_count;

    // Host / bench side.
    modport master (
        output start, mode, step, abort, core_halt, pc, bp_addr, bp_en,
        input  run, busy, done, halt_reason, bp_hit_idx, cycle_count
    );

    // Controller side.
    modport slave (
        input  start, mode, step, abort, core_halt, pc, bp_addr, bp_en,
        output run, busy, done, halt_reason, bp_hit_idx, cycle_count
    );
endinterface

// File: rtl/pipeline_run_ctrl.sv
// Run/halt controller for the pipelined core: free-run with cycle limit,
// single-step and run-to-breakpoint, reporting why and when it stopped.
module pipeline_run_ctrl #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned CYCLE_WIDTH = 16,
    parameter int unsigned NUM_BP      = 2,
    parameter int unsigned MAX_CYCLES  = 50,
    parameter int unsigned START_DELAY = 1
) (
    input  logic               clk,
    input  logic               rst,
    pipeline_run_ctrl_if.slave bus
);
    localparam int unsigned BP_IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
    localparam int unsigned DLY_W    = (START_DELAY > 1) ? $clog2(START_DELAY + 1) : 1;
    localparam bit          LIMIT_EN = (MAX_CYCLES != 0);
    localparam logic [CYCLE_WIDTH-1:0] LIMIT_M1 =
        LIMIT_EN ? CYCLE_WIDTH'(MAX_CYCLES - 1) : '0;

    localparam logic [1:0] MODE_STEP = 2'd1;
    localparam logic [1:0] MODE_BP   = 2'd2;

    localparam logic [2:0] R_NONE  = 3'd0;
    localparam logic [2:0] R_HALT  = 3'd1;
    localparam logic [2:0] R_BP    = 3'd2;
    localparam logic [2:0] R_LIMIT = 3'd3;
    localparam logic [2:0] R_ABORT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_RUN,
        S_STEP_WAIT,
        S_STEP_RUN,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [DLY_W-1:0]       dly_q, dly_d;
    logic                   run_q, run_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [2:0]             halt_reason_q, halt_reason_d;
    logic [BP_IDX_W-1:0]    bp_hit_idx_q, bp_hit_idx_d;
    logic [CYCLE_WIDTH-1:0] cycle_count_q, cycle_count_d;

    logic                   bp_hit_c;
    logic [BP_IDX_W-1:0]    bp_idx_c;
    logic                   stop_c;
    logic [2:0]             stop_reason_c;

    // Breakpoint compare on the live PC; scanning downward leaves the lowest index.
    always_comb begin
        bp_hit_c = 1'b0;
        bp_idx_c = '0;
        for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
            if (bus.bp_en[i] && (bus.pc == bus.bp_addr[i*PC_WIDTH +: PC_WIDTH])) begin
                bp_hit_c = 1'b1;
                bp_idx_c = BP_IDX_W'(i);
            end
        end
    end

    // Prioritised stop condition, meaningful only in cycles with run high.
    always_comb begin
        stop_c        = 1'b0;
        stop_reason_c = R_NONE;
        if (bus.abort) begin
            stop_c        = 1'b1;
            stop_reason_c = R_ABORT;
        end else if (bus.core_halt) begin
            stop_c        = 1'b1;
            stop_reason_c = R_HALT;
        end else if ((mode_q == MODE_BP) && bp_hit_c) begin
            stop_c        = 1'b1;
            stop_reason_c = R_BP;
        end else if (LIMIT_EN && (cycle_count_q == LIMIT_M1)) begin
            stop_c        = 1'b1;
            stop_reason_c = R_LIMIT;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        dly_d         = dly_q;
        halt_reason_d = halt_reason_q;
        bp_hit_idx_d  = bp_hit_idx_q;
        cycle_count_d = cycle_count_q;
        if (run_q && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + CYCLE_WIDTH'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    mode_d        = bus.mode;
                    cycle_count_d = '0;
                    halt_reason_d = R_NONE;
                    bp_hit_idx_d  = '0;
                    if (START_DELAY == 0) begin
                        state_d = (bus.mode == MODE_STEP) ? S_STEP_WAIT : S_RUN;
                    end else begin
                        state_d = S_DELAY;
                        dly_d   = DLY_W'(START_DELAY);
                    end
                end
            end
            S_DELAY: begin
                if (bus.abort) begin
                    state_d       = S_DONE;
                    halt_reason_d = R_ABORT;
                end else if (dly_q <= DLY_W'(1)) begin
                    state_d = (mode_q == MODE_STEP) ? S_STEP_WAIT : S_RUN;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            S_RUN, S_STEP_RUN: begin
                if (stop_c) begin
                    state_d       = S_DONE;
                    halt_reason_d = stop_reason_c;
                    if (stop_reason_c == R_BP) begin
                        bp_hit_idx_d = bp_idx_c;
                    end
                end else if (state_q == S_STEP_RUN) begin
                    state_d = S_STEP_WAIT;
                end
            end
            S_STEP_WAIT: begin
                if (bus.abort) begin
                    state_d       = S_DONE;
                    halt_reason_d = R_ABORT;
                end else if (bus.core_halt) begin
                    state_d       = S_DONE;
                    halt_reason_d = R_HALT;
                end else if (bus.step) begin
                    state_d = S_STEP_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        run_d  = (state_d == S_RUN) || (state_d == S_STEP_RUN);
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mode_q        <= 2'd0;
            dly_q         <= '0;
            run_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            halt_reason_q <= R_NONE;
            bp_hit_idx_q  <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            dly_q         <= dly_d;
            run_q         <= run_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            halt_reason_q <= halt_reason_d;
            bp_hit_idx_q  <= bp_hit_idx_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign bus.run         = run_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.halt_reason = halt_reason_q;
    assign bus.bp_hit_idx  = bp_hit_idx_q;
    assign bus.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Scoreboard bench for pipeline_run_ctrl: default instance plus an
// unlimited / zero-delay / 4-bit-counter instance.
module tb_pipeline_run_ctrl;
    localparam int unsigned PCW  = 32;
    localparam int unsigned CW   = 16;
    localparam int unsigned NBP  = 2;
    localparam int unsigned MAXC = 50;
    localparam int unsigned SD   = 1;

    typedef struct {
        int reason;
        int cnt;
        int idx;
        int runs;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_run_ctrl_if #(.PC_WIDTH(PCW), .CYCLE_WIDTH(CW), .NUM_BP(NBP)) ifc ();
    pipeline_run_ctrl_if #(.PC_WIDTH(PCW), .CYCLE_WIDTH(4), .NUM_BP(NBP)) ifc2 ();

    pipeline_run_ctrl #(
        .PC_WIDTH(PCW), .CYCLE_WIDTH(CW), .NUM_BP(NBP),
        .MAX_CYCLES(MAXC), .START_DELAY(SD)
    ) u_dut (.clk(clk), .rst(rst), .bus(ifc));

    pipeline_run_ctrl #(
        .PC_WIDTH(PCW), .CYCLE_WIDTH(4), .NUM_BP(NBP),
        .MAX_CYCLES(0), .START_DELAY(0)
    ) u_dut2 (.clk(clk), .rst(rst), .bus(ifc2));

    logic abort_man, abort_auto, halt_auto;
    assign ifc.abort     = abort_man | abort_auto;
    assign ifc.core_halt = halt_auto;

    int   halt_at;
    int   abort_at;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: walk run cycles and take the first stop by priority.
    task automatic model(input int md, input int h, input int a, input logic [1:0] en,
                         input logic [31:0] a0, input logic [31:0] a1, output exp_t e);
        logic [31:0] p;
        int r;
        int ix;
        e = '{0, 0, 0, 0};
        for (int n = 1; n <= int'(MAXC); n++) begin
            p  = 32'(4 * (n - 1));
            r  = 0;
            ix = 0;
            if (n == a) r = 4;
            else if (n == h) r = 1;
            else if (md == 2 && ((en[0] && p == a0) || (en[1] && p == a1))) begin
                r  = 2;
                ix = (en[0] && p == a0) ? 0 : 1;
            end else if (n == int'(MAXC)) r = 3;
            if (r != 0) begin
                e.reason = r;
                e.cnt    = n;
                e.idx    = ix;
                e.runs   = n;
                break;
            end
        end
    endtask

    // Core stand-in: pc ramps by 4 per run cycle; halt/abort fire at chosen run cycles.
    initial begin
        int run_idx;
        run_idx    = 0;
        halt_auto  = 1'b0;
        abort_auto = 1'b0;
        ifc.pc     = '0;
        forever begin
            @(negedge clk);
            if (!ifc.busy) run_idx = 0;
            if (ifc.run) begin
                run_idx++;
                ifc.pc     = PCW'(4 * (run_idx - 1));
                halt_auto  = (halt_at != 0) && (run_idx == halt_at);
                abort_auto = (abort_at != 0) && (run_idx == abort_at);
            end else begin
                halt_auto  = 1'b0;
                abort_auto = 1'b0;
            end
        end
    end

    // Monitor: counts run cycles per launch and checks each done against the queue.
    initial begin
        int   mon_runs;
        logic done_prev;
        logic busy_prev;
        exp_t e;
        mon_runs  = 0;
        done_prev = 1'b0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc.busy && !busy_prev) mon_runs = 0;
            if (ifc.run) mon_runs++;
            if (ifc.done && !done_prev && !rst) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("halt_reason", longint'(ifc.halt_reason), e.reason);
                    check("cycle_count", longint'(ifc.cycle_count), e.cnt);
                    check("run_cycles", mon_runs, e.runs);
                    if (e.reason == 2) check("bp_hit_idx", longint'(ifc.bp_hit_idx), e.idx);
                    check("busy_at_done", longint'(ifc.busy), 0);
                    check("run_at_done", longint'(ifc.run), 0);
                end
            end
            done_prev = ifc.done;
            busy_prev = ifc.busy;
        end
    end

    task automatic wait_done(input int budget);
        int k = 0;
        while (!ifc.done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!ifc.done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got done=0 expected done=1 within %0d cycles", budget);
        end
    endtask

    task automatic run_scenario(input int md, input int h, input int a, input logic [1:0] en,
                                input logic [31:0] a0, input logic [31:0] a1, input bit sa);
        exp_t e;
        model(md, h, a, en, a0, a1, e);
        exp_q.push_back(e);
        @(negedge clk);
        halt_at     = h;
        abort_at    = a;
        ifc.bp_en   = en;
        ifc.bp_addr = {a1, a0};
        ifc.mode    = 2'(md);
        ifc.start   = 1'b1;
        abort_man   = sa;
        @(negedge clk);
        ifc.start = 1'b0;
        abort_man = 1'b0;
        wait_done(300);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    // Main stimulus sequence.
    initial begin
        exp_t e;
        int   runs;
        int   k;
        int   sel;
        rst         = 1'b1;
        ifc.start   = 1'b0;
        ifc.mode    = 2'd0;
        ifc.step    = 1'b0;
        ifc.bp_en   = '0;
        ifc.bp_addr = '0;
        abort_man   = 1'b0;
        halt_at     = 0;
        abort_at    = 0;
        ifc2.start     = 1'b0;
        ifc2.mode      = 2'd0;
        ifc2.step      = 1'b0;
        ifc2.abort     = 1'b0;
        ifc2.core_halt = 1'b0;
        ifc2.pc        = '0;
        ifc2.bp_en     = '0;
        ifc2.bp_addr   = '0;

        repeat (2) @(negedge clk);
        check("rst_run", longint'(ifc.run), 0);
        check("rst_busy", longint'(ifc.busy), 0);
        check("rst_done", longint'(ifc.done), 0);
        check("rst_reason", longint'(ifc.halt_reason), 0);
        check("rst_bp_idx", longint'(ifc.bp_hit_idx), 0);
        check("rst_count", longint'(ifc.cycle_count), 0);
        rst = 1'b0;

        // Free-run to the cycle limit, with start-delay check.
        model(0, 0, 0, 2'b00, 0, 0, e);
        exp_q.push_back(e);
        @(negedge clk);
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        check("delay_run_low", longint'(ifc.run), 0);
        check("delay_busy", longint'(ifc.busy), 1);
        @(negedge clk);
        check("first_run_high", longint'(ifc.run), 1);
        wait_done(200);

        // Breakpoint on index 1, then both enabled at same address.
        run_scenario(2, 0, 0, 2'b10, 32'h0, 32'h40, 1'b0);
        run_scenario(2, 0, 0, 2'b11, 32'h40, 32'h40, 1'b0);
        // Breakpoints are ignored outside mode 2.
        run_scenario(0, 0, 0, 2'b01, 32'h20, 32'h0, 1'b0);
        // abort beats core_halt; then core_halt alone.
        run_scenario(0, 10, 10, 2'b00, 0, 0, 1'b0);
        run_scenario(0, 7, 0, 2'b00, 0, 0, 1'b0);
        // start with abort from DONE: abort ignored; mode 3 acts as free-run.
        run_scenario(3, 0, 0, 2'b00, 0, 0, 1'b1);

        // Abort during the start delay.
        exp_q.push_back('{4, 0, 0, 0});
        @(negedge clk);
        ifc.mode  = 2'd0;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        abort_man = 1'b1;
        @(negedge clk);
        abort_man = 1'b0;
        wait_done(20);

        // Single-step: three spaced pulses, then step held high.
        @(negedge clk);
        ifc.mode  = 2'd1;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            ifc.step = 1'b1;
            @(negedge clk);
            ifc.step = 1'b0;
            repeat (4) @(negedge clk);
        end
        check("step_count", longint'(ifc.cycle_count), 3);
        check("step_done", longint'(ifc.done), 0);
        check("step_busy", longint'(ifc.busy), 1);
        check("step_run_idle", longint'(ifc.run), 0);
        ifc.step = 1'b1;
        repeat (6) @(negedge clk);
        ifc.step = 1'b0;
        @(negedge clk);
        check("step_held_count", longint'(ifc.cycle_count), 6);
        exp_q.push_back('{4, 6, 0, 6});
        abort_man = 1'b1;
        @(negedge clk);
        abort_man = 1'b0;
        wait_done(20);

        // Randomized launches against the model.
        for (int t = 0; t < 16; t++) begin
            sel = int'($urandom_range(0, 2));
            run_scenario((sel == 0) ? 0 : (sel == 1) ? 2 : 3,
                         int'($urandom_range(0, 60)), int'($urandom_range(0, 60)),
                         2'($urandom_range(0, 3)),
                         32'(4 * $urandom_range(0, 60)), 32'(4 * $urandom_range(0, 60)),
                         1'($urandom_range(0, 1)));
        end

        // Reset mid-run at run cycle 20, with start held during reset.
        @(negedge clk);
        halt_at   = 0;
        abort_at  = 0;
        ifc.mode  = 2'd0;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        runs = 0;
        k    = 0;
        while (runs < 20 && k < 200) begin
            @(negedge clk);
            k++;
            if (ifc.run) runs++;
        end
        check("reached_run20", runs, 20);
        rst       = 1'b1;
        ifc.start = 1'b1;
        @(negedge clk);
        check("midrst_run", longint'(ifc.run), 0);
        check("midrst_count", longint'(ifc.cycle_count), 0);
        check("midrst_done", longint'(ifc.done), 0);
        check("midrst_busy", longint'(ifc.busy), 0);
        @(negedge clk);
        rst       = 1'b0;
        ifc.start = 1'b0;
        repeat (2) @(negedge clk);
        check("start_in_rst_ignored", longint'(ifc.busy), 0);
        check("idle_run_low", longint'(ifc.run), 0);

        // Unlimited, zero-delay, 4-bit counter instance.
        @(negedge clk);
        ifc2.start = 1'b1;
        @(negedge clk);
        ifc2.start = 1'b0;
        check("d2_run_after_start", longint'(ifc2.run), 1);
        repeat (20) @(negedge clk);
        check("d2_count_sat", longint'(ifc2.cycle_count), 15);
        check("d2_run_still_high", longint'(ifc2.run), 1);
        check("d2_busy", longint'(ifc2.busy), 1);
        ifc2.abort = 1'b1;
        @(negedge clk);
        ifc2.abort = 1'b0;
        check("d2_done", longint'(ifc2.done), 1);
        check("d2_reason", longint'(ifc2.halt_reason), 4);
        check("d2_run_low", longint'(ifc2.run), 0);
        check("d2_count_final", longint'(ifc2.cycle_count), 15);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
